// File: rtl/register32.sv
// register32 -- parallel-load data register for the CPU datapath
//
// Holds one WIDTH-bit word (PC, pipeline and holding registers). The word
// is captured from `in` on a rising clock edge while `load` is high and is
// held otherwise. An asynchronous active-high reset forces the stored word
// to RESET_VALUE immediately, independent of the clock.
//
// Ports (declaration order is fixed for positional instantiation):
//   clk   in   1      clock, all updates on the rising edge
//   in    in   WIDTH  data word to capture
//   rst   in   1      asynchronous reset, active-high
//   load  in   1      capture enable, active-high
//   out   out  WIDTH  stored word, driven directly by the flops
//
// There is no combinational path from `in` or `load` to `out`. The stored
// word is unknown until the first reset or load, so users must reset first.

module register32 #(
    parameter int unsigned            WIDTH       = 32,
    parameter logic [WIDTH-1:0]       RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] in,
    input  logic             rst,
    input  logic             load,
    output logic [WIDTH-1:0] out
);

    // Reset is tested first so it wins over load at any clock edge, and it
    // sits in the sensitivity list so its rising edge acts without a clock.
    // NOTE: non-blocking assignment keeps every flop sampling pre-edge
    // values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out <= RESET_VALUE;
        end else if (load) begin
            out <= in;
        end
    end

endmodule

// File: tb/tb_register32.sv
// tb_register32 -- self-checking bench for register32
//
// Directed scenarios (async reset, reset priority, release, hold, back-to-back
// loads) followed by randomized load/data traffic with occasional
// asynchronous reset pulses, all compared against a behavioural model.

module tb_register32;

    logic        clk;
    logic        clk_en;
    logic [31:0] in;
    logic        rst;
    logic        load;
    logic [31:0] out;

    // Behavioural model: the word the register should be holding.
    logic [31:0] model;

    int checks;
    int errors;

    register32 dut (
        .clk  (clk),
        .in   (in),
        .rst  (rst),
        .load (load),
        .out  (out)
    );

    // Clock stays low until enabled so the reset path can be seen without it.
    initial clk = 1'b0;
    always #5 if (clk_en) clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference rule for one rising edge: reset clears, load captures,
    // otherwise the word is kept.
    task automatic model_edge(input logic r, input logic ld, input logic [31:0] d);
        if (r)       model = 32'h0;
        else if (ld) model = d;
    endtask

    // Drive inputs at the falling edge, let one rising edge pass, then sample.
    task automatic cycle(input logic ld, input logic [31:0] d, input string tag);
        @(negedge clk);
        load = ld;
        in   = d;
        @(posedge clk);
        model_edge(rst, ld, d);
        #1;
        check(tag, out, model);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clk_en = 1'b0;
        rst    = 1'b0;
        load   = 1'b0;
        in     = 32'h0;
        model  = 32'hx;

        // 1. Asynchronous reset with no clock running.
        #3 rst = 1'b1;
        #1 model = 32'h0;
        check("async_rst_noclk", out, model);

        clk_en = 1'b1;
        // Reset priority: load=1 with all-ones must not get through.
        cycle(1'b1, 32'hFFFF_FFFF, "rst_over_load");
        cycle(1'b1, 32'hFFFF_FFFF, "rst_over_load2");

        // 2. Release, load zero over several edges.
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h0, "load_zero");

        // 3. Preload all-ones, then reset between edges.
        cycle(1'b1, 32'hFFFF_FFFF, "preload_ones");
        #2 rst = 1'b1;
        #1 model = 32'h0;
        check("async_rst_midcycle", out, model);
        cycle(1'b1, 32'hFFFF_FFFF, "rst_hold");
        cycle(1'b1, 32'hFFFF_FFFF, "rst_hold2");

        // 4. Release with load pending: nothing before the edge, capture on it.
        @(negedge clk);
        rst  = 1'b0;
        load = 1'b1;
        in   = 32'hFFFF_FFFF;
        #1 check("no_capture_before_edge", out, model);
        @(posedge clk);
        model_edge(rst, load, in);
        #1 check("first_edge_after_release", out, model);

        // 5. Hold with load low while in changes.
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0000_1111, "hold");

        // 6. Back-to-back loads.
        cycle(1'b1, 32'h1234_5678, "b2b_first");
        cycle(1'b1, 32'hA5A5_A5A5, "b2b_second");

        // Randomized traffic with occasional asynchronous reset pulses.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            load = 1'($urandom_range(0, 1));
            in   = $urandom;
            if ($urandom_range(0, 15) == 0) begin
                rst = 1'b1;
                #1 model = 32'h0;
                check("rand_async_rst", out, model);
                #1 rst = 1'b0;
            end
            @(posedge clk);
            model_edge(rst, load, in);
            #1 check("rand_cycle", out, model);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
